// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Signed ops run on magnitudes; the sign is fixed up in a single final cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   a_lat;
    logic [WIDTH-1:0]   bmag;
    logic [2*WIDTH-1:0] acc;

    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_rem;
    logic               div_ok;
    logic [2*WIDTH-1:0] acc_next;

    function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_if_wide(input logic n, input logic [2*WIDTH-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

    // op[0] set means unsigned, so signs only count for MULT/DIV
    assign sign_a = ~op[0] & a[WIDTH-1];
    assign sign_b = ~op[0] & b[WIDTH-1];
    assign mag_a  = neg_if(sign_a, a);
    assign mag_b  = neg_if(sign_b, b);

    // acc holds {partial product | remainder, multiplier | quotient} for both ops
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bmag} : {(WIDTH+1){1'b0}});
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ok    = div_shift >= {1'b0, bmag};
        div_rem   = div_shift[WIDTH-1:0] - bmag;
        acc_next  = {mul_sum, acc[WIDTH-1:1]};
        if (is_div)
            acc_next = {(div_ok ? div_rem : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ok};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            a_lat       <= '0;
            bmag        <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        neg_q  <= sign_a ^ sign_b;
                        neg_r  <= sign_a;
                        a_lat  <= a;
                        bmag   <= mag_b;
                        acc    <= {{WIDTH{1'b0}}, mag_a};
                        count  <= CW'(WIDTH);
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    count <= count - CW'(1);
                    if (count == CW'(1))
                        state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (!is_div) begin
                        {hi, lo} <= neg_if_wide(neg_q, acc);
                    end else if (bmag == '0) begin
                        hi          <= a_lat;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        lo <= neg_if(neg_q, acc[WIDTH-1:0]);
                        hi <= neg_if(neg_r, acc[2*WIDTH-1:WIDTH]);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
